// File: rtl/hdb3_pkg.sv
`default_nettype none
// ============================================================================
// Module : hdb3_pkg
// Brief  : Shared constants, tag type and width helper for the HDB3 scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package hdb3_pkg;

    localparam int SYM_W    = 3;
    // Tag channel field is sized for the largest supported channel count (8).
    localparam int CH_MAX_W = 3;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef struct packed {
        logic                vld;
        logic [CH_MAX_W-1:0] ch;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/hdb3_rr_arb.sv
`default_nettype none
// ============================================================================
// Module : hdb3_rr_arb
// Brief  : Round-robin arbiter, one-hot grant, pointer advances past winner.
// Rev    : 1.0  initial release
// ============================================================================
module hdb3_rr_arb
    import hdb3_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NCH-1:0]      req,
    output logic [NCH-1:0]      grant,
    output logic [CH_MAX_W-1:0] gnt_idx
);

    logic [CH_MAX_W-1:0] ptr;
    logic                found;

    // First pass covers ptr..NCH-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!found && req[c] && (CH_MAX_W'(c) >= ptr)) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                gnt_idx  = CH_MAX_W'(c);
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                gnt_idx  = CH_MAX_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CH_MAX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hdb3_dec_sched.sv
`default_nettype none
// ============================================================================
// Module : hdb3_dec_sched
// Brief  : Time-shares one HDB3 decoder among NCH channels with tag routing.
// Rev    : 1.0  initial release
// ============================================================================
module hdb3_dec_sched
    import hdb3_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DEC_LAT = 1,
    parameter int ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_en_i,
    input  logic [3*NCH-1:0]     sym_i,
    input  logic [NCH-1:0]       sym_vld_i,
    output logic [NCH-1:0]       sym_rdy_o,
    output logic [2:0]           dec_sym_o,
    output logic                 dec_vld_o,
    input  logic                 dec_data_i,
    input  logic                 dec_err_i,
    input  logic                 dec_vld_i,
    output logic [NCH-1:0]       out_data_o,
    output logic [NCH-1:0]       out_err_o,
    output logic [NCH-1:0]       out_vld_o,
    input  logic                 err_clr_i,
    output logic [ERR_W*NCH-1:0] err_cnt_o,
    output logic                 proto_err_o
);

    logic [NCH-1:0]      req;
    logic [NCH-1:0]      grant;
    logic [CH_MAX_W-1:0] gnt_idx;
    logic                xfer;
    logic [SYM_W-1:0]    gnt_sym;
    tag_t                tag_q [DEC_LAT+1];
    tag_t                tag_last;
    logic [2:0]          blank_cnt;
    logic [ERR_W-1:0]    cnt [NCH];

    assign req       = sym_vld_i & ch_en_i & {NCH{~rst}};
    assign sym_rdy_o = grant;
    assign xfer      = |grant;
    assign tag_last  = tag_q[DEC_LAT];

    hdb3_rr_arb #(
        .NCH (NCH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        gnt_sym = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant[c]) begin
                gnt_sym = sym_i[SYM_W*c +: SYM_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_vld_o <= 1'b0;
            dec_sym_o <= '0;
        end else begin
            dec_vld_o <= xfer;
            if (xfer) begin
                dec_sym_o <= gnt_sym;
            end
        end
    end

    // Stage 0 travels with the issue register; stage DEC_LAT meets dec_vld_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEC_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: xfer, ch: gnt_idx};
            for (int i = 1; i <= DEC_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_o  <= '0;
            out_err_o   <= '0;
            out_vld_o   <= '0;
            proto_err_o <= 1'b0;
            blank_cnt   <= 3'(DEC_LAT + 1);
        end else begin
            out_vld_o <= '0;
            if (dec_vld_i && tag_last.vld) begin
                for (int c = 0; c < NCH; c++) begin
                    if (tag_last.ch == CH_MAX_W'(c)) begin
                        out_data_o[c] <= dec_data_i;
                        out_err_o[c]  <= dec_err_i;
                        out_vld_o[c]  <= 1'b1;
                    end
                end
            end
            // Responses still draining from before reset must not flag errors.
            if (dec_vld_i && !tag_last.vld && (blank_cnt == 3'd0)) begin
                proto_err_o <= 1'b1;
            end
            if (blank_cnt != 3'd0) begin
                blank_cnt <= blank_cnt - 3'd1;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst || err_clr_i) begin
                cnt[c] <= '0;
            end else if (out_vld_o[c] && out_err_o[c] && (cnt[c] != {ERR_W{1'b1}})) begin
                cnt[c] <= cnt[c] + ERR_W'(1);
            end
        end
        assign err_cnt_o[ERR_W*c +: ERR_W] = cnt[c];
    end

endmodule
`default_nettype wire

// File: tb/tb_hdb3_dec_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_hdb3_dec_sched
// Brief  : Directed bench; two instances (decoder latency 1 and 3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_hdb3_dec_sched;

    localparam int NCH   = 4;
    localparam int ERR_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic [NCH-1:0]       en = '0;
    logic [3*NCH-1:0]     sym = '0;
    logic [NCH-1:0]       vld = '0;
    logic                 clr = 1'b0;
    logic                 stray = 1'b0;
    logic                 drop = 1'b0;
    logic                 force_err = 1'b0;

    logic [NCH-1:0]       a_rdy, a_odata, a_oerr, a_ovld;
    logic [2:0]           a_dsym;
    logic                 a_dvld, a_proto, a_dvi, a_ddi, a_dei;
    logic [ERR_W*NCH-1:0] a_cnt;
    logic [NCH-1:0]       b_rdy, b_odata, b_oerr, b_ovld;
    logic [2:0]           b_dsym;
    logic                 b_dvld, b_proto, b_dvi, b_ddi, b_dei;
    logic [ERR_W*NCH-1:0] b_cnt;

    // Decoder model: data = sym[0], error when symbol is 111 (or forced).
    logic       a_v1 = 1'b0;
    logic [2:0] a_s1 = '0;
    logic [2:0] b_v  = '0;
    logic [8:0] b_s  = '0;
    always @(posedge clk) begin
        a_v1 <= a_dvld;
        a_s1 <= a_dsym;
        b_v  <= {b_v[1:0], b_dvld};
        b_s  <= {b_s[5:0], b_dsym};
    end
    assign a_dvi = (a_v1 & ~drop) | stray;
    assign a_ddi = a_s1[0];
    assign a_dei = (a_s1 == 3'b111) | force_err;
    assign b_dvi = b_v[2];
    assign b_ddi = b_s[6];
    assign b_dei = (b_s[8:6] == 3'b111) | force_err;

    hdb3_dec_sched #(.NCH(NCH), .DEC_LAT(1), .ERR_W(ERR_W)) u_dut_a (
        .clk(clk), .rst(rst), .ch_en_i(en), .sym_i(sym), .sym_vld_i(vld),
        .sym_rdy_o(a_rdy), .dec_sym_o(a_dsym), .dec_vld_o(a_dvld),
        .dec_data_i(a_ddi), .dec_err_i(a_dei), .dec_vld_i(a_dvi),
        .out_data_o(a_odata), .out_err_o(a_oerr), .out_vld_o(a_ovld),
        .err_clr_i(clr), .err_cnt_o(a_cnt), .proto_err_o(a_proto)
    );

    hdb3_dec_sched #(.NCH(NCH), .DEC_LAT(3), .ERR_W(ERR_W)) u_dut_b (
        .clk(clk), .rst(rst), .ch_en_i(en), .sym_i(sym), .sym_vld_i(vld),
        .sym_rdy_o(b_rdy), .dec_sym_o(b_dsym), .dec_vld_o(b_dvld),
        .dec_data_i(b_ddi), .dec_err_i(b_dei), .dec_vld_i(b_dvi),
        .out_data_o(b_odata), .out_err_o(b_oerr), .out_vld_o(b_ovld),
        .err_clr_i(clr), .err_cnt_o(b_cnt), .proto_err_o(b_proto)
    );

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sym(input int c, input logic [2:0] s);
        sym[3*c +: 3] = s;
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = '0; en = '0; clr = 1'b0;
        stray = 1'b0; drop = 1'b0; force_err = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '1; vld = '1; sym = 12'hFFF;
        tick();
        tick();
        checks++; if (a_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rdy: got %b want 0000", a_rdy); end
        checks++; if (a_dvld !== 1'b0) begin errors++; $display("FAIL rst_dvld: got %b want 0", a_dvld); end
        checks++; if (a_dsym !== 3'b000) begin errors++; $display("FAIL rst_dsym: got %b want 000", a_dsym); end
        checks++; if (a_ovld !== 4'b0000) begin errors++; $display("FAIL rst_ovld: got %b want 0000", a_ovld); end
        checks++; if (a_odata !== 4'b0000) begin errors++; $display("FAIL rst_odata: got %b want 0000", a_odata); end
        checks++; if (a_oerr !== 4'b0000) begin errors++; $display("FAIL rst_oerr: got %b want 0000", a_oerr); end
        checks++; if (a_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", a_cnt); end
        checks++; if (a_proto !== 1'b0) begin errors++; $display("FAIL rst_proto: got %b want 0", a_proto); end
        vld = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        en = '1;
        set_sym(2, 3'b001);
        vld = 4'b0100;
        #1;
        checks++; if (a_rdy !== 4'b0100) begin errors++; $display("FAIL single_rdy: got %b want 0100", a_rdy); end
        tick();
        vld = '0;
        checks++; if (a_dvld !== 1'b1 || a_dsym !== 3'b001) begin errors++; $display("FAIL single_issue: got vld=%b sym=%b want 1/001", a_dvld, a_dsym); end
        tick();
        checks++; if (a_ovld !== 4'b0000) begin errors++; $display("FAIL single_early: got %b want 0000", a_ovld); end
        tick();
        checks++; if (a_ovld !== 4'b0100 || a_odata[2] !== 1'b1) begin errors++; $display("FAIL single_out: got vld=%b data=%b want 0100/1", a_ovld, a_odata); end
        tick();
        checks++; if (a_ovld !== 4'b0000 || a_odata[2] !== 1'b1) begin errors++; $display("FAIL single_hold: got vld=%b data=%b want 0000/x1xx", a_ovld, a_odata); end
        checks++; if (b_ovld !== 4'b0000) begin errors++; $display("FAIL single_b_early: got %b want 0000", b_ovld); end
        tick();
        checks++; if (b_ovld !== 4'b0100 || b_odata[2] !== 1'b1) begin errors++; $display("FAIL single_b_out: got vld=%b data=%b want 0100/1", b_ovld, b_odata); end
    endtask

    task automatic test_fairness();
        do_reset();
        en = '1;
        for (int c = 0; c < NCH; c++) set_sym(c, 3'(c + 1));
        vld = '1;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (a_rdy !== 4'(1 << (k % 4))) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, a_rdy, 4'(1 << (k % 4))); end
            tick();
            checks++; if (a_dvld !== 1'b1 || a_dsym !== 3'(k % 4 + 1)) begin errors++; $display("FAIL fair_issue%0d: got vld=%b sym=%b want 1/%b", k, a_dvld, a_dsym, 3'(k % 4 + 1)); end
        end
        vld = '0;
        repeat (6) tick();
    endtask

    task automatic test_errors();
        do_reset();
        en = '1;
        force_err = 1'b1;
        set_sym(1, 3'b101);
        vld = 4'b0010;
        repeat (254) tick();
        vld = '0;
        repeat (6) tick();
        checks++; if (a_cnt[15:8] !== 8'd254 || a_cnt[7:0] !== 8'd0) begin errors++; $display("FAIL err_cnt254: got ch1=%0d ch0=%0d want 254/0", a_cnt[15:8], a_cnt[7:0]); end
        vld = 4'b0010;
        repeat (46) tick();
        vld = '0;
        repeat (6) tick();
        checks++; if (a_cnt[15:8] !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d want 255", a_cnt[15:8]); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (a_cnt !== 32'h0) begin errors++; $display("FAIL err_clr: got %h want 0", a_cnt); end
        vld = 4'b0010;
        tick();
        vld = '0;
        repeat (6) tick();
        checks++; if (a_cnt[15:8] !== 8'd1) begin errors++; $display("FAIL err_one: got %0d want 1", a_cnt[15:8]); end
        vld = 4'b0010;
        tick();
        vld = '0;
        tick();
        tick();
        checks++; if (a_ovld !== 4'b0010 || a_oerr[1] !== 1'b1) begin errors++; $display("FAIL err_strobe: got vld=%b err=%b want 0010/x x1x", a_ovld, a_oerr); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (a_cnt[15:8] !== 8'd0) begin errors++; $display("FAIL err_clr_wins: got %0d want 0", a_cnt[15:8]); end
        force_err = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_mask();
        do_reset();
        en = 4'b1110;
        set_sym(0, 3'b001);
        vld = 4'b0001;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (a_rdy !== 4'b0000) begin errors++; $display("FAIL mask_rdy%0d: got %b want 0000", k, a_rdy); end
            tick();
            checks++; if (a_dvld !== 1'b0) begin errors++; $display("FAIL mask_dvld%0d: got %b want 0", k, a_dvld); end
        end
        vld = 4'b0000;
        en = 4'b1111;
        set_sym(3, 3'b011);
        vld = 4'b1000;
        #1;
        checks++; if (a_rdy !== 4'b1000) begin errors++; $display("FAIL mask_ch3_rdy: got %b want 1000", a_rdy); end
        tick();
        en = 4'b0111;
        #1;
        checks++; if (a_rdy !== 4'b0000) begin errors++; $display("FAIL mask_ch3_off: got %b want 0000", a_rdy); end
        tick();
        tick();
        checks++; if (a_ovld !== 4'b1000 || a_odata[3] !== 1'b1) begin errors++; $display("FAIL mask_inflight: got vld=%b data=%b want 1000/1xxx", a_ovld, a_odata); end
        vld = '0;
        repeat (3) tick();
    endtask

    task automatic test_proto();
        do_reset();
        repeat (3) tick();
        checks++; if (a_proto !== 1'b0) begin errors++; $display("FAIL proto_idle: got %b want 0", a_proto); end
        en = '1;
        set_sym(0, 3'b001);
        vld = 4'b0001;
        tick();
        vld = '0;
        drop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (a_ovld !== 4'b0000) begin errors++; $display("FAIL proto_drop%0d: got %b want 0000", k, a_ovld); end
        end
        drop = 1'b0;
        checks++; if (a_proto !== 1'b0) begin errors++; $display("FAIL proto_drop_flag: got %b want 0", a_proto); end
        stray = 1'b1;
        tick();
        stray = 1'b0;
        checks++; if (a_proto !== 1'b1) begin errors++; $display("FAIL proto_set: got %b want 1", a_proto); end
        checks++; if (a_ovld !== 4'b0000) begin errors++; $display("FAIL proto_no_strobe: got %b want 0000", a_ovld); end
        repeat (3) tick();
        checks++; if (a_proto !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", a_proto); end
        set_sym(1, 3'b011);
        vld = 4'b0011;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vld = '0;
        stray = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (a_ovld !== 4'b0000) begin errors++; $display("FAIL rst_mid_ovld%0d: got %b want 0000", k, a_ovld); end
            tick();
        end
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (a_proto !== 1'b0 || a_ovld !== 4'b0000) begin errors++; $display("FAIL rst_mid_quiet%0d: got proto=%b vld=%b want 0/0000", k, a_proto, a_ovld); end
            tick();
        end
    endtask

    task automatic test_latency();
        logic [5:0] qa[$];
        logic [5:0] qb[$];
        logic [5:0] exp_e;
        logic [5:0] obs;
        do_reset();
        en = '1;
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (a_ovld != 4'b0000) begin
                checks++;
                obs = {a_ovld, |(a_odata & a_ovld), |(a_oerr & a_ovld)};
                if (qa.size() == 0) begin
                    errors++; $display("FAIL lat_a_route: got strobe %b want none", a_ovld);
                end else begin
                    exp_e = qa.pop_front();
                    if (obs !== exp_e) begin errors++; $display("FAIL lat_a_route: got %b want %b", obs, exp_e); end
                end
            end
            if (b_ovld != 4'b0000) begin
                checks++;
                obs = {b_ovld, |(b_odata & b_ovld), |(b_oerr & b_ovld)};
                if (qb.size() == 0) begin
                    errors++; $display("FAIL lat_b_route: got strobe %b want none", b_ovld);
                end else begin
                    exp_e = qb.pop_front();
                    if (obs !== exp_e) begin errors++; $display("FAIL lat_b_route: got %b want %b", obs, exp_e); end
                end
            end
            if (cyc < 300) begin
                vld = 4'($urandom);
                sym = 12'($urandom);
            end else begin
                vld = '0;
            end
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (vld[c] && a_rdy[c]) qa.push_back({4'(1 << c), sym[3*c], sym[3*c +: 3] == 3'b111});
                if (vld[c] && b_rdy[c]) qb.push_back({4'(1 << c), sym[3*c], sym[3*c +: 3] == 3'b111});
            end
            tick();
        end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL lat_a_drain: got %0d pending want 0", qa.size()); end
        checks++; if (qb.size() != 0) begin errors++; $display("FAIL lat_b_drain: got %0d pending want 0", qb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_errors();
        test_mask();
        test_proto();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
